// File: rtl/sparse_vector_feeder_if.sv
// Handshake and data bundle between the lane feeder, its upstream beat source and the downstream dot-product stage.
interface sparse_vector_feeder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_a;
  logic [7:0]   in_b;
  logic         in_flush;
  logic         vec_valid;
  logic         vec_ready;
  logic [127:0] Vector_A;
  logic [127:0] Vector_B;
  logic [15:0]  nz_mask;
  logic [4:0]   nz_count;

  modport slave (
    input  in_valid, in_a, in_b, in_flush, vec_ready,
    output in_ready, vec_valid, Vector_A, Vector_B, nz_mask, nz_count
  );

  modport master (
    output in_valid, in_a, in_b, in_flush, vec_ready,
    input  in_ready, vec_valid, Vector_A, Vector_B, nz_mask, nz_count
  );
endinterface

// File: rtl/sparse_vector_feeder.sv
// Packs 8-bit A/B beats into 16-lane vector pairs with a registered non-zero lane mask and count.
module sparse_vector_feeder (
  input  logic                    clk,
  input  logic                    rst,
  sparse_vector_feeder_if.slave   bus
);
  localparam int unsigned LANES = 16;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]   r_state;
  logic [3:0]   r_lane_cnt;
  logic [127:0] r_vec_a;
  logic [127:0] r_vec_b;
  logic [15:0]  r_nz_mask;
  logic [4:0]   r_nz_count;

  logic         w_accept;
  logic         w_last;
  logic         w_nz;
  logic [6:0]   w_lane_lsb;

  assign w_accept   = bus.in_valid && (r_state == FILL);
  assign w_last     = (r_lane_cnt == 4'(LANES - 1));
  assign w_nz       = (bus.in_a != 8'd0) && (bus.in_b != 8'd0);
  assign w_lane_lsb = {r_lane_cnt, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FILL;
      r_lane_cnt <= '0;
      r_vec_a    <= '0;
      r_vec_b    <= '0;
      r_nz_mask  <= '0;
      r_nz_count <= '0;
    end else if (r_state == FILL) begin
      if (w_accept) begin
        r_vec_a[w_lane_lsb +: 8] <= bus.in_a;
        r_vec_b[w_lane_lsb +: 8] <= bus.in_b;
        r_nz_mask[r_lane_cnt]    <= w_nz;
        r_nz_count               <= r_nz_count + {4'd0, w_nz};
        r_lane_cnt               <= r_lane_cnt + 4'd1;
      end
      // A flush only closes a vector that holds at least one beat, counting the one landing now.
      if ((w_accept && (w_last || bus.in_flush)) ||
          (bus.in_flush && (r_lane_cnt != 4'd0)))
        r_state <= FULL;
    end else begin
      if (bus.vec_ready) begin
        r_state    <= FILL;
        r_lane_cnt <= '0;
        r_vec_a    <= '0;
        r_vec_b    <= '0;
        r_nz_mask  <= '0;
        r_nz_count <= '0;
      end
    end
  end

  assign bus.in_ready  = (r_state == FILL);
  assign bus.vec_valid = (r_state == FULL);
  assign bus.Vector_A  = r_vec_a;
  assign bus.Vector_B  = r_vec_b;
  assign bus.nz_mask   = r_nz_mask;
  assign bus.nz_count  = r_nz_count;
endmodule

// File: tb/tb_sparse_vector_feeder.sv
// Directed scenarios plus randomized traffic checked each cycle against an array-based vector model.
module tb_sparse_vector_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  sparse_vector_feeder_if bus ();

  sparse_vector_feeder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mA [16];
  logic [7:0] mB [16];
  int         m_cnt;
  bit         m_full;

  // Reference: a list of accepted lanes; a vector is "full" once 16 lanes exist or a non-empty flush arrives.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin mA[i] = 8'd0; mB[i] = 8'd0; end
      m_cnt  = 0;
      m_full = 1'b0;
    end else if (!m_full) begin
      if (bus.in_valid) begin
        mA[m_cnt] = bus.in_a;
        mB[m_cnt] = bus.in_b;
        m_cnt++;
      end
      if (m_cnt == 16 || (bus.in_flush && m_cnt > 0)) m_full = 1'b1;
    end else if (bus.vec_ready) begin
      for (int i = 0; i < 16; i++) begin mA[i] = 8'd0; mB[i] = 8'd0; end
      m_cnt  = 0;
      m_full = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [127:0] ea, eb;
    logic [15:0]  em;
    ea = '0; eb = '0; em = '0;
    for (int i = 0; i < 16; i++) begin
      ea[i*8 +: 8] = mA[i];
      eb[i*8 +: 8] = mB[i];
      em[i]        = (mA[i] != 8'd0) && (mB[i] != 8'd0);
    end
    chk("model.in_ready",  128'(bus.in_ready),  128'(!m_full));
    chk("model.vec_valid", 128'(bus.vec_valid), 128'(m_full));
    chk("model.Vector_A",  bus.Vector_A, ea);
    chk("model.Vector_B",  bus.Vector_B, eb);
    chk("model.nz_mask",   128'(bus.nz_mask), 128'(em));
    chk("model.nz_count",  128'(bus.nz_count), 128'($countones(em)));
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic f);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_flush = f;
    idle(1);
    bus.in_valid = 1'b0; bus.in_flush = 1'b0;
  endtask

  initial begin
    logic [127:0] cap;
    logic [127:0] ones;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_flush = 1'b0; bus.vec_ready = 1'b0;
    ones = '1;
    #3;
    chk("reset.vec_valid", 128'(bus.vec_valid), 128'd0);
    chk("reset.in_ready",  128'(bus.in_ready),  128'd1);
    chk("reset.Vector_A",  bus.Vector_A, 128'd0);
    chk("reset.nz_count",  128'(bus.nz_count), 128'd0);
    @(posedge clk); #1; rst = 1'b0;

    // All-ones vector with vec_ready held high.
    bus.vec_ready = 1'b1;
    for (int i = 0; i < 16; i++) beat(8'hFF, 8'hFF, 1'b0);
    chk("ones.vec_valid", 128'(bus.vec_valid), 128'd1);
    chk("ones.Vector_A",  bus.Vector_A, ones);
    chk("ones.Vector_B",  bus.Vector_B, ones);
    chk("ones.nz_mask",   128'(bus.nz_mask), 128'h0FFFF);
    chk("ones.nz_count",  128'(bus.nz_count), 128'd16);
    idle(1);
    chk("ones.vec_valid_drop", 128'(bus.vec_valid), 128'd0);

    // Alternating zero B lanes.
    bus.vec_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat(8'(i + 1), (i % 2 == 1) ? 8'd2 : 8'd0, 1'b0);
    chk("alt.nz_mask",  128'(bus.nz_mask), 128'h0AAAA);
    chk("alt.nz_count", 128'(bus.nz_count), 128'd8);
    chk("alt.lane0",    128'(bus.Vector_A[7:0]), 128'h01);
    chk("alt.lane15",   128'(bus.Vector_A[127:120]), 128'h10);
    bus.vec_ready = 1'b1; idle(1); bus.vec_ready = 1'b0;

    // Short vector closed by a flush.
    for (int i = 0; i < 3; i++) beat(8'h05, 8'h05, 1'b0);
    bus.in_flush = 1'b1; idle(1); bus.in_flush = 1'b0;
    chk("flush.vec_valid", 128'(bus.vec_valid), 128'd1);
    chk("flush.Vector_A",  bus.Vector_A, 128'h050505);
    chk("flush.nz_mask",   128'(bus.nz_mask), 128'h7);
    chk("flush.nz_count",  128'(bus.nz_count), 128'd3);
    bus.vec_ready = 1'b1; idle(1); bus.vec_ready = 1'b0;

    // Backpressure while upstream keeps offering beats.
    cap = '0;
    for (int i = 0; i < 16; i++) begin
      cap[i*8 +: 8] = 8'(i * 3 + 1);
      beat(8'(i * 3 + 1), 8'h01, 1'b0);
    end
    bus.in_valid = 1'b1; bus.in_a = 8'hEE; bus.in_b = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("stall.in_ready", 128'(bus.in_ready), 128'd0);
      chk("stall.Vector_A", bus.Vector_A, cap);
    end
    bus.in_valid = 1'b0; bus.vec_ready = 1'b1; idle(1); bus.vec_ready = 1'b0;
    chk("stall.refill_ready", 128'(bus.in_ready), 128'd1);
    beat(8'h3C, 8'h3C, 1'b0);
    chk("stall.lane0", bus.Vector_A, 128'h3C);
    bus.in_flush = 1'b1; idle(1); bus.in_flush = 1'b0;
    bus.vec_ready = 1'b1; idle(1); bus.vec_ready = 1'b0;

    // Reset mid-fill discards the partial vector immediately.
    for (int i = 0; i < 7; i++) beat(8'h22, 8'h22, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.Vector_A", bus.Vector_A, 128'd0);
    chk("rstmid.nz_mask",  128'(bus.nz_mask), 128'd0);
    chk("rstmid.in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 16; i++) beat(8'h11, 8'h11, 1'b0);
    chk("rstmid.refill", bus.Vector_A, {16{8'h11}});
    bus.vec_ready = 1'b1; idle(1); bus.vec_ready = 1'b0;

    // Flush on an empty vector, then flush coinciding with the 16th beat.
    bus.in_flush = 1'b1; idle(1); bus.in_flush = 1'b0;
    chk("emptyflush.vec_valid", 128'(bus.vec_valid), 128'd0);
    for (int i = 0; i < 15; i++) beat(8'h07, 8'h07, 1'b0);
    beat(8'h07, 8'h07, 1'b1);
    chk("flush16.vec_valid", 128'(bus.vec_valid), 128'd1);
    chk("flush16.nz_count",  128'(bus.nz_count), 128'd16);
    bus.vec_ready = 1'b1; idle(1);
    chk("flush16.drop", 128'(bus.vec_valid), 128'd0);
    idle(1);
    chk("flush16.no_extra", 128'(bus.vec_valid), 128'd0);
    bus.vec_ready = 1'b0;

    // Randomized traffic with occasional asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 499) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_flush  = ($urandom_range(0, 19) == 0);
      bus.vec_ready = $urandom_range(0, 1) == 1;
      bus.in_a      = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      bus.in_b      = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0; bus.in_valid = 1'b0; bus.in_flush = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
